// File: rtl/axis_conv_in_fifo_if.sv
// Conv-beat stream interface: handshake plus pixels, weights, tuser and tlast.
// master drives valid and payload; slave drives ready.
//   tvalid/tready  handshake
//   tlast          last beat of a weight block
//   tuser          conv tuser
//   pixels_tdata   PIX_WIDTH pixel bits
//   weights_tdata  WGT_WIDTH weight bits
interface axis_conv_in_fifo_if #(
    parameter int unsigned PIX_WIDTH   = 64,
    parameter int unsigned WGT_WIDTH   = 32,
    parameter int unsigned TUSER_WIDTH = 4
);
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [PIX_WIDTH-1:0]   pixels_tdata;
    logic [WGT_WIDTH-1:0]   weights_tdata;

    modport master (
        output tvalid,
        output tlast,
        output tuser,
        output pixels_tdata,
        output weights_tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tuser,
        input  pixels_tdata,
        input  weights_tdata,
        output tready
    );
endinterface

// File: rtl/axis_conv_in_fifo.sv
// Registered elastic buffer in front of the conv engine. Holds up to DEPTH
// complete conv beats; both tready and tvalid come from flops so the engine's
// tready never reaches the pixel/weight pipes combinationally. Also keeps
// beat, packet and stall counters for the debug_config bus.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   s_axis          slave side of the joined pixels/weights stream
//   m_axis          master side towards the conv engine
//   fill_count      entries currently held (A+1 bits)
//   beats_count     output handshakes since reset (wraps)
//   packets_count   output handshakes with tlast since reset (wraps)
//   stall_count     cycles with tvalid high and tready low (saturates)
module axis_conv_in_fifo #(
    parameter int unsigned UNITS               = 4,
    parameter int unsigned CORES               = 2,
    parameter int unsigned COPIES              = 2,
    parameter int unsigned MEMBERS             = 2,
    parameter int unsigned WORD_WIDTH          = 8,
    parameter int unsigned TUSER_WIDTH_CONV_IN = 4,
    parameter int unsigned DEPTH               = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axis_conv_in_fifo_if.slave            s_axis,
    axis_conv_in_fifo_if.master           m_axis,
    output logic [$clog2(DEPTH):0]        fill_count,
    output logic [31:0]                   beats_count,
    output logic [15:0]                   packets_count,
    output logic [15:0]                   stall_count
);
    localparam int unsigned P  = COPIES * WORD_WIDTH * UNITS;
    localparam int unsigned W  = WORD_WIDTH * CORES * MEMBERS;
    localparam int unsigned A  = $clog2(DEPTH);
    localparam int unsigned CW = A + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of 2 and at least 2");
    end

    typedef struct packed {
        logic                           tlast;
        logic [TUSER_WIDTH_CONV_IN-1:0] tuser;
        logic [P-1:0]                   pixels;
        logic [W-1:0]                   weights;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [A-1:0]   wr_ptr_q, wr_ptr_d;
    logic [A-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  fill_q, fill_d;
    logic           s_tready_q, s_tready_d;
    logic           m_tvalid_q, m_tvalid_d;
    logic [31:0]    beats_count_q, beats_count_d;
    logic [15:0]    packets_count_q, packets_count_d;
    logic [15:0]    stall_count_q, stall_count_d;
    logic           push_c;
    logic           pop_c;
    entry_t         head_c;
    entry_t         wr_entry_c;

    // Handshakes are qualified only by registered ready/valid.
    assign push_c = s_axis.tvalid & s_tready_q;
    assign pop_c  = m_tvalid_q & m_axis.tready;

    assign wr_entry_c = '{
        tlast:   s_axis.tlast,
        tuser:   s_axis.tuser,
        pixels:  s_axis.pixels_tdata,
        weights: s_axis.weights_tdata
    };

    // Next-state for pointers, occupancy, handshake flops and counters.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        fill_d          = fill_q;
        beats_count_d   = beats_count_q;
        packets_count_d = packets_count_q;
        stall_count_d   = stall_count_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + A'(1);
        end
        if (pop_c) begin
            rd_ptr_d        = rd_ptr_q + A'(1);
            beats_count_d   = beats_count_q + 32'd1;
            packets_count_d = packets_count_q + 16'(head_c.tlast);
        end
        fill_d = fill_q + CW'(push_c) - CW'(pop_c);

        if (m_tvalid_q && !m_axis.tready && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end

        s_tready_d = (fill_d < CW'(DEPTH));
        m_tvalid_d = (fill_d != '0);
    end

    // Control and counter registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fill_q          <= '0;
            s_tready_q      <= 1'b0;
            m_tvalid_q      <= 1'b0;
            beats_count_q   <= '0;
            packets_count_q <= '0;
            stall_count_q   <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fill_q          <= fill_d;
            s_tready_q      <= s_tready_d;
            m_tvalid_q      <= m_tvalid_d;
            beats_count_q   <= beats_count_d;
            packets_count_q <= packets_count_d;
            stall_count_q   <= stall_count_d;
        end
    end

    // Storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge aclk) begin
        if (aresetn && push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

    assign head_c = mem_q[rd_ptr_q];

    assign s_axis.tready        = s_tready_q;
    assign m_axis.tvalid        = m_tvalid_q;
    assign m_axis.tlast         = head_c.tlast;
    assign m_axis.tuser         = head_c.tuser;
    assign m_axis.pixels_tdata  = head_c.pixels;
    assign m_axis.weights_tdata = head_c.weights;

    assign fill_count    = fill_q;
    assign beats_count   = beats_count_q;
    assign packets_count = packets_count_q;
    assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_axis_conv_in_fifo.sv
// Scoreboard bench for axis_conv_in_fifo: the driver queues each accepted
// beat, an independent monitor pops and compares every output handshake.
module tb_axis_conv_in_fifo;
    localparam int unsigned UNITS   = 4;
    localparam int unsigned CORES   = 2;
    localparam int unsigned COPIES  = 2;
    localparam int unsigned MEMBERS = 2;
    localparam int unsigned WW      = 8;
    localparam int unsigned TU      = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned P       = COPIES * WW * UNITS;
    localparam int unsigned W       = WW * CORES * MEMBERS;
    localparam int unsigned A       = $clog2(DEPTH);

    typedef struct packed {
        logic          tl;
        logic [TU-1:0] tu;
        logic [P-1:0]  px;
        logic [W-1:0]  wt;
    } beat_t;

    logic          aclk;
    logic          aresetn;
    logic [A:0]    fill_count;
    logic [31:0]   beats_count;
    logic [15:0]   packets_count;
    logic [15:0]   stall_count;

    axis_conv_in_fifo_if #(.PIX_WIDTH(P), .WGT_WIDTH(W), .TUSER_WIDTH(TU)) s_if ();
    axis_conv_in_fifo_if #(.PIX_WIDTH(P), .WGT_WIDTH(W), .TUSER_WIDTH(TU)) m_if ();

    axis_conv_in_fifo #(
        .UNITS(UNITS), .CORES(CORES), .COPIES(COPIES), .MEMBERS(MEMBERS),
        .WORD_WIDTH(WW), .TUSER_WIDTH_CONV_IN(TU), .DEPTH(DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis        (s_if.slave),
        .m_axis        (m_if.master),
        .fill_count    (fill_count),
        .beats_count   (beats_count),
        .packets_count (packets_count),
        .stall_count   (stall_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_pops   = 0;
    beat_t exp_q[$];
    logic  last_push;

    function automatic beat_t mk(input logic tl, input logic [31:0] val);
        beat_t b;
        b.tl = tl;
        b.tu = TU'(val);
        b.px = P'(val);
        b.wt = ~W'(val);
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, then log the push
    // that the coming rising edge will perform.
    task automatic step(input logic rn, input logic tv, input logic tl,
                        input logic [31:0] val, input logic mr);
        beat_t b;
        @(negedge aclk);
        b                   = mk(tl, val);
        aresetn             = rn;
        s_if.tvalid         = tv;
        s_if.tlast          = b.tl;
        s_if.tuser          = b.tu;
        s_if.pixels_tdata   = b.px;
        s_if.weights_tdata  = b.wt;
        m_if.tready         = mr;
        #1;
        last_push = rn && tv && s_if.tready;
        if (last_push) exp_q.push_back(b);
    endtask

    task automatic drain();
        int k = 0;
        while (m_if.tvalid && k < 100) begin
            step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
            k++;
        end
        chk("drain_empty", 64'(m_if.tvalid), 64'd0);
    endtask

    // Monitor: checks every output handshake and the hold rule under stall.
    beat_t cur, prev, e;
    logic  hold_prev = 1'b0;
    always begin
        @(negedge aclk);
        #2;
        cur = '{tl: m_if.tlast, tu: m_if.tuser, px: m_if.pixels_tdata, wt: m_if.weights_tdata};
        if (aresetn) begin
            if (hold_prev) begin
                n_checks++;
                if (!m_if.tvalid || cur !== prev) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b got %h expected %h", m_if.tvalid, cur, prev);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL beat_data: got %h expected %h", cur, e);
                    end
                end
                n_pops++;
            end
            hold_prev = m_if.tvalid && !m_if.tready;
            prev      = cur;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        int accepted;
        int cyc;
        aresetn            = 1'b0;
        s_if.tvalid        = 1'b0;
        s_if.tlast         = 1'b0;
        s_if.tuser         = '0;
        s_if.pixels_tdata  = '0;
        s_if.weights_tdata = '0;
        m_if.tready        = 1'b0;

        // Reset values
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_fill", 64'(fill_count), 64'd0);
        chk("rst_beats", 64'(beats_count), 64'd0);
        chk("rst_packets", 64'(packets_count), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("ready_after_release", 64'(s_if.tready), 64'd1);

        // Passthrough: each beat visible the cycle after its push
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i == 7), 32'(i), 1'b1);
            if (i > 0) begin
                chk("pt_latency_valid", 64'(m_if.tvalid), 64'd1);
                chk("pt_fill", 64'(fill_count), 64'd1);
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("pt_last_valid", 64'(m_if.tvalid), 64'd1);
        chk("pt_last_tlast", 64'(m_if.tlast), 64'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("pt_empty", 64'(m_if.tvalid), 64'd0);
        chk("pt_beats", 64'(beats_count), 64'd8);
        chk("pt_packets", 64'(packets_count), 64'd1);

        // Fill to full with tready low
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'(100 + i), 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("full_s_tready", 64'(s_if.tready), 64'd0);
        chk("full_fill", 64'(fill_count), 64'd4);
        chk("full_stall5", 64'(stall_count), 64'd5);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("full_stall6", 64'(stall_count), 64'd6);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'd200, 1'b0);
        chk("pop1_s_tready", 64'(s_if.tready), 64'd1);
        chk("pop1_fill", 64'(fill_count), 64'd3);

        // Full plus simultaneous pop
        step(1'b1, 1'b1, 1'b0, 32'd201, 1'b1);
        chk("fp_fill4", 64'(fill_count), 64'd4);
        chk("fp_no_push", 64'(last_push), 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'd202, 1'b1);
        chk("fp_fill3", 64'(fill_count), 64'd3);
        chk("fp_ready", 64'(s_if.tready), 64'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("fp_fill_hold", 64'(fill_count), 64'd3);

        // Reset mid-operation with three entries held
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        exp_q.delete();
        n_pops = 0;
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("mr_valid", 64'(m_if.tvalid), 64'd0);
        chk("mr_fill", 64'(fill_count), 64'd0);
        chk("mr_beats", 64'(beats_count), 64'd0);
        chk("mr_packets", 64'(packets_count), 64'd0);
        chk("mr_stall", 64'(stall_count), 64'd0);
        chk("mr_ready_low", 64'(s_if.tready), 64'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("mr_ready_high", 64'(s_if.tready), 64'd1);
        chk("mr_no_stale", 64'(m_if.tvalid), 64'd0);
        step(1'b1, 1'b1, 1'b0, 32'd300, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("mr_new_valid", 64'(m_if.tvalid), 64'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("mr_pops", 64'(n_pops), 64'd1);

        // Counter edges
        force dut.beats_count_q = 32'hFFFF_FFFF;
        force dut.stall_count_q = 16'hFFFE;
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        release dut.beats_count_q;
        release dut.stall_count_q;
        chk("ce_beats_pre", 64'(beats_count), 64'hFFFF_FFFF);
        chk("ce_stall_pre", 64'(stall_count), 64'hFFFE);
        step(1'b1, 1'b1, 1'b1, 32'd400, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("ce_stall_sat", 64'(stall_count), 64'hFFFF);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("ce_beats_wrap", 64'(beats_count), 64'd0);
        chk("ce_packets", 64'(packets_count), 64'd1);
        chk("ce_stall_hold", 64'(stall_count), 64'hFFFF);

        // Random backpressure from a fresh reset
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        exp_q.delete();
        n_pops   = 0;
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 60000) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom), 1'($urandom_range(0, 1)));
            if (last_push) accepted++;
            cyc++;
        end
        chk("rnd_accepted", 64'(accepted), 64'd10000);
        drain();
        chk("rnd_pops", 64'(n_pops), 64'd10000);
        chk("rnd_beats", 64'(beats_count), 64'(n_pops));
        chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_conv_in_fifo.md
# axis_conv_in_fifo

Registered elastic buffer between the input pipe (joined pixels and weights stream) and the conv engine input. It stores up to DEPTH complete conv beats (pixels, weights, tuser, tlast) and drives both handshake directions from registers, so the conv engine's tready never combinationally reaches the pixel and weight pipes. It also keeps beat, packet and stall counters that feed the debug_config bus.

## Interface
- UNITS, `UNITS: rows per core; sets pixel width.
- CORES, `CORES: number of conv cores.
- COPIES, `COPIES: pixel stream copies (1 or 2).
- MEMBERS, `MEMBERS: weight members per core.
- WORD_WIDTH, `WORD_WIDTH: bits per word.
- TUSER_WIDTH_CONV_IN, `TUSER_WIDTH_CONV_IN: conv tuser width.
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.

Ports (P = COPIES·WORD_WIDTH·UNITS, W = WORD_WIDTH·CORES·MEMBERS, A = log2(DEPTH)):
- aclk  in  1  clock. Single clock domain; all logic is on the rising edge.
- aresetn  in  1  reset. Synchronous and active-low.
- s_axis_tready  out  1  space available (registered).
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of a weight block.
- s_axis_tuser  in  TUSER_WIDTH_CONV_IN  conv tuser.
- s_axis_pixels_tdata  in  P  pixels.
- s_axis_weights_tdata  in  W  weights.
- m_axis_tready  in  1  conv engine ready.
- m_axis_tvalid  out  1  output beat valid (registered).
- m_axis_tlast  out  1  tlast of the head entry.
- m_axis_tuser  out  TUSER_WIDTH_CONV_IN  tuser of the head entry.
- m_axis_pixels_tdata  out  P  pixels of the head entry.
- m_axis_weights_tdata  out  W  weights of the head entry.
- fill_count  out  A+1  number of entries currently held.
- beats_count  out  32  output handshakes since reset.
- packets_count  out  16  output handshakes with tlast since reset.
- stall_count  out  16  cycles with m_axis_tvalid high and m_axis_tready low.

## Operation
- The storage is a DEPTH-entry register array. Each entry holds {tlast, tuser, pixels, weights}.
- Pointers: wr_ptr and rd_ptr are A bits each and wrap modulo DEPTH. fill_count is tracked separately.
- push = s_axis_tvalid & s_axis_tready. Writes entry[wr_ptr], then wr_ptr+1.
- pop = m_axis_tvalid & m_axis_tready. rd_ptr+1.
- fill_count next value = fill_count + push − pop. Push and pop in the same cycle leave it unchanged.
- s_axis_tready register next value = (next fill_count < DEPTH).
- m_axis_tvalid register next value = (next fill_count != 0).
- The m_axis data, tuser and tlast outputs are entry[rd_ptr], read combinationally from the registers. They are defined only while m_axis_tvalid is high. All fields pass through bit-exact; tuser is not re-gated.
- Full (fill_count = DEPTH): s_axis_tready is low and no push can occur, even if pop is high in the same cycle. s_axis_tready rises on the next cycle.
- Empty: m_axis_tvalid is low and no pop can occur. A push into an empty FIFO is visible on the next cycle.
- Counters:
  - beats_count increments on pop and wraps at 2^32.
  - packets_count increments on pop with m_axis_tlast and wraps at 2^16.
  - stall_count saturates at 16'hFFFF.
- Reset (aresetn low at a rising edge, including mid-operation):
  - Pointers, fill_count, all counters, s_axis_tready and m_axis_tvalid clear to 0.
  - All held entries are discarded. Storage contents are not cleared.
  - s_axis_tready goes high on the first edge with aresetn high.

## Timing
- Latency: a beat pushed at edge N appears with m_axis_tvalid high after edge N (cycle N+1), provided the FIFO was empty.
- Throughput: one beat per cycle in steady state, with m_axis_tready continuously high.
- There is no combinational path from m_axis_tready to s_axis_tready, or from s_axis_tvalid to m_axis_tvalid.
- AXI-Stream rules:
  - m_axis_tvalid, once high, stays high, with data stable, until pop.
  - s_axis_tready may drop only as a result of fill_count reaching DEPTH.
- Reset values of outputs:
  - s_axis_tready=0, m_axis_tvalid=0.
  - fill_count=0, beats_count=0, packets_count=0, stall_count=0.
  - m_axis data, tuser and tlast are don't-care.

## Test plan
- **Passthrough.** Send 8 beats with pixels = i, weights = ~i and tlast on beat 7, with m_axis_tready=1.
  - Output order is 0..7 with identical fields and tlast on the 8th beat.
  - Each beat appears 1 cycle after it is pushed.
  - Final counts: beats_count=8, packets_count=1.
- **Fill to full.** Hold m_axis_tready=0 and present 6 beats.
  - 4 beats are accepted, then s_axis_tready=0 and fill_count=4.
  - stall_count increments every cycle from the first valid output.
  - Raising m_axis_tready for one cycle makes s_axis_tready=1 on the following cycle.
- **Full plus simultaneous pop.** At fill_count=4, set s_axis_tvalid=1 and m_axis_tready=1.
  - Exactly 1 pop occurs and 0 pushes that cycle; fill_count becomes 3.
  - On the next cycle push and pop coexist and fill_count stays at 3.
- **Random backpressure.** Drive random s_axis_tvalid and m_axis_tready at 50% for 10,000 beats.
  - The scoreboard sees no loss, duplication or reordering.
  - No output changes while m_axis_tvalid=1 and m_axis_tready=0.
  - beats_count matches the scoreboard count.
- **Reset mid-operation.** Assert aresetn=0 for 1 cycle while fill_count=3.
  - The next cycle shows m_axis_tvalid=0, fill_count=0 and all counters at 0.
  - s_axis_tready=1 one cycle after release.
  - Stale entries never reappear.
- **Counter edges.** Preload or force beats_count to 32'hFFFFFFFF and stall_count to 16'hFFFE.
  - One pop wraps beats_count to 0.
  - Two stall cycles leave stall_count at 16'hFFFF.
